// File: rtl/control_unit.sv
// control_unit: opcode decoder with sticky illegal-opcode flag; CONTROL_BRANCH_CNT_EN adds a taken-branch counter
module control_unit #(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] instr,
  input  logic           equal,
  output logic           RegDst,
  output logic           Branch,
  output logic           MemtoReg,
  output logic           MemWrite,
  output logic           ALUSrc,
  output logic           RegWrite,
  output logic [OPW-1:0] ALUOp,
  output logic           illegal
`ifdef CONTROL_BRANCH_CNT_EN
  ,
  output logic [7:0]     branch_cnt
`endif
);
  logic w_reg_wr;
  logic w_mem_wr;
  logic w_branch;
  logic w_illegal_op;
  logic r_illegal;
  // raw decode of the opcode; write and branch strobes are gated by reset below
  always_comb begin
    RegDst       = instr inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    ALUSrc       = instr inside {4'h1, 4'h2, 4'h7, 4'hA, 4'hB, 4'hC};
    w_reg_wr     = instr inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hC};
    w_mem_wr     = instr == 4'hB;
    MemtoReg     = instr == 4'hC;
    w_branch     = instr == 4'h8 ? ~equal : instr == 4'h9 ? equal : 1'b0;
    w_illegal_op = instr inside {4'hD, 4'hE};
  end
  assign ALUOp    = instr;
  assign RegWrite = w_reg_wr & ~reset;
  assign MemWrite = w_mem_wr & ~reset;
  assign Branch   = w_branch & ~reset;
  assign illegal  = r_illegal;
  // sticky record of undefined opcodes, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else if (w_illegal_op) r_illegal <= 1'b1;
  end
`ifdef CONTROL_BRANCH_CNT_EN
  logic [7:0] r_branch_cnt;
  assign branch_cnt = r_branch_cnt;
  // wrapping count of taken branches outside reset
  always_ff @(posedge clk) begin
    if (reset) r_branch_cnt <= 8'd0;
    else if (w_branch) r_branch_cnt <= r_branch_cnt + 8'd1;
  end
`else
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven scoreboard bench for control_unit
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] instr;
  logic       equal;
  logic       RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, illegal;
  logic [3:0] ALUOp;
`ifdef CONTROL_BRANCH_CNT_EN
  logic [7:0] branch_cnt;
`endif
  logic [9:0] act;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] instr;
    logic       equal;
    logic       rst;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[23];
  logic [9:0] sb[$];

  control_unit dut (
    .clk(clk), .reset(reset), .instr(instr), .equal(equal),
    .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal(illegal)
`ifdef CONTROL_BRANCH_CNT_EN
    , .branch_cnt(branch_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign act = {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp};

  task automatic chk(input string nm, input logic [9:0] a, input logic [9:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] i, input logic e, input logic r);
    instr = i;
    equal = e;
    reset = r;
    #1;
  endtask

  initial begin
    // fields: RegDst Branch MemtoReg MemWrite ALUSrc RegWrite ALUOp
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 10'b100001_0000};
    tbl[1]  = '{4'h1, 1'b0, 1'b0, 10'b100011_0001};
    tbl[2]  = '{4'h2, 1'b0, 1'b0, 10'b100011_0010};
    tbl[3]  = '{4'h3, 1'b0, 1'b0, 10'b100001_0011};
    tbl[4]  = '{4'h4, 1'b0, 1'b0, 10'b100001_0100};
    tbl[5]  = '{4'h5, 1'b0, 1'b0, 10'b100001_0101};
    tbl[6]  = '{4'h6, 1'b0, 1'b0, 10'b100001_0110};
    tbl[7]  = '{4'h7, 1'b0, 1'b0, 10'b000011_0111};
    tbl[8]  = '{4'h8, 1'b1, 1'b0, 10'b000000_1000};
    tbl[9]  = '{4'h8, 1'b0, 1'b0, 10'b010000_1000};
    tbl[10] = '{4'h9, 1'b1, 1'b0, 10'b010000_1001};
    tbl[11] = '{4'h9, 1'b0, 1'b0, 10'b000000_1001};
    tbl[12] = '{4'hA, 1'b0, 1'b0, 10'b000011_1010};
    tbl[13] = '{4'hB, 1'b1, 1'b0, 10'b000110_1011};
    tbl[14] = '{4'hC, 1'b0, 1'b0, 10'b001011_1100};
    tbl[15] = '{4'hF, 1'b1, 1'b0, 10'b000000_1111};
    tbl[16] = '{4'h0, 1'b1, 1'b0, 10'b100001_0000};
    tbl[17] = '{4'h7, 1'b1, 1'b0, 10'b000011_0111};
    tbl[18] = '{4'hC, 1'b0, 1'b1, 10'b001010_1100};
    tbl[19] = '{4'h9, 1'b1, 1'b1, 10'b000000_1001};
    tbl[20] = '{4'hB, 1'b0, 1'b1, 10'b000010_1011};
    tbl[21] = '{4'h0, 1'b0, 1'b1, 10'b100000_0000};
    tbl[22] = '{4'h8, 1'b0, 1'b1, 10'b000000_1000};

    drive(4'hF, 1'b0, 1'b1);
    tick();
    tick();
    chk("reset_illegal", {9'd0, illegal}, 10'd0);

    for (int k = 0; k < 23; k++) begin
      sb.push_back(tbl[k].exp);
      drive(tbl[k].instr, tbl[k].equal, tbl[k].rst);
      chk($sformatf("vec%0d_op%h", k, tbl[k].instr), act, sb.pop_front());
      tick();
    end

    drive(4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nop_illegal_low", {9'd0, illegal}, 10'd0);
    end

    drive(4'hD, 1'b0, 1'b0);
    chk("op_d_strobes", act, 10'b000000_1101);
    tick();
    chk("illegal_set_d", {9'd0, illegal}, 10'd1);
    drive(4'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("illegal_sticky", {9'd0, illegal}, 10'd1);
    drive(4'h0, 1'b0, 1'b1);
    tick();
    chk("illegal_reset", {9'd0, illegal}, 10'd0);
    drive(4'hE, 1'b0, 1'b0);
    chk("op_e_strobes", act, 10'b000000_1110);
    tick();
    chk("illegal_set_e", {9'd0, illegal}, 10'd1);
    drive(4'hD, 1'b0, 1'b1);
    tick();
    chk("reset_priority", {9'd0, illegal}, 10'd0);

`ifdef CONTROL_BRANCH_CNT_EN
    drive(4'h0, 1'b0, 1'b1);
    tick();
    chk("cnt_reset", {2'd0, branch_cnt}, 10'd0);
    drive(4'h9, 1'b1, 1'b0);
    tick();
    chk("cnt_one", {2'd0, branch_cnt}, 10'd1);
    for (int k = 1; k < 255; k++) tick();
    chk("cnt_255", {2'd0, branch_cnt}, 10'd255);
    tick();
    chk("cnt_wrap", {2'd0, branch_cnt}, 10'd0);
    tick();
    drive(4'h8, 1'b1, 1'b0);
    tick();
    chk("cnt_not_taken", {2'd0, branch_cnt}, 10'd1);
    drive(4'h8, 1'b0, 1'b1);
    tick();
    chk("cnt_gated_reset", {2'd0, branch_cnt}, 10'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
